// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
//   Iterative unsigned restoring divider. It produces one quotient bit per
//   clock, MSB first, and uses valid/ready handshakes on both sides.
//   Latency from the accept edge to out_valid is WIDTH cycles. A divide by
//   zero completes in the cycle after the accept edge.
//
// Ports
//   clk, rst_n            rising-edge clock; asynchronous active-low reset
//   in_valid / in_ready   operand handshake (dividend, divisor)
//   out_valid / out_ready result handshake (quotient, remainder, div_by_zero)
//   quotient, remainder   unsigned results; both are held stable while stalled
//   div_by_zero           the result came from divisor == 0
//                         (quotient = all ones, remainder = dividend)
//
// All outputs are decoded from registers, so no input reaches an output
// through combinational logic.
module seq_restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // The quotient bits shift in from the right as the dividend shifts out
  // from the left, so one register holds both values.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  // The stored partial remainder is always below the divisor, so its bit
  // WIDTH is 0 between steps. Only the low WIDTH bits are kept in a
  // register. The full WIDTH+1-bit value exists only inside a step, which
  // means maximum operands cannot overflow.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    // One restoring step: shift {rem, dvd} left by one, then trial-subtract.
    shifted = {rem_q, dvd_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d = dividend;
          dvs_d = divisor;
          rem_d = '0;
          cnt_d = '0;
          if (divisor == '0) begin
            dvd_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            dbz_d   = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = dvd_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Iterative unsigned restoring divider; inverse operation of the recursive Vedic multiplier datapath.
- Produces one quotient bit per clock, MSB first, with a valid/ready handshake on both input and output.
- Sits beside the multiplier in the arithmetic cluster.
- Bench closes the loop: quotient*divisor + remainder is checked against the dividend using the multiplier.

Parameters:
- WIDTH, 32, operand width in bits; any value >= 2 is legal; 4/8/16/32/64 are regressed.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  divider can accept operands
- dividend  input  WIDTH  unsigned dividend
- divisor  input  WIDTH  unsigned divisor
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  unsigned quotient
- remainder  output  WIDTH  unsigned remainder
- div_by_zero  output  1  current result came from divisor == 0

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n low forces state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
  - Reset asserted mid-operation aborts the operation; no partial result is ever presented.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept occurs on an edge where in_valid && in_ready; that edge is edge k.
  - At edge k, register dividend into the shift register, divisor into the divisor register, clear the partial remainder (WIDTH+1 bits) and clear the counter.
  - If divisor==0 at edge k, go to DONE with quotient=all ones, remainder=dividend, div_by_zero=1. out_valid is high in the cycle after edge k.
  - Otherwise go to CALC with div_by_zero=0.
- CALC:
  - in_ready=0; in_valid and operand changes are ignored.
  - Each edge does one restoring step:
    - shift {partial remainder, dividend shift register} left by 1;
    - trial = partial remainder - {1'b0, divisor} in WIDTH+1 bits;
    - if trial is non-negative (MSB 0), partial remainder = trial and the new quotient LSB = 1;
    - otherwise keep the partial remainder and set the quotient LSB = 0.
  - The counter increments each step. After step WIDTH, at edge k+WIDTH, go to DONE.
  - out_valid is first high in the cycle following edge k+WIDTH, so latency is exactly WIDTH cycles from accept to out_valid.
- DONE:
  - out_valid=1, in_ready=0.
  - quotient, remainder and div_by_zero are stable and unchanged while out_valid && !out_ready.
  - The edge with out_valid && out_ready goes to IDLE. in_ready rises the following cycle; no same-cycle accept on the drain edge.
- Outputs are registered only; there is no combinational path from any input to any output.
- Arithmetic: unsigned only.
  - remainder < divisor always holds when divisor != 0.
  - quotient*divisor + remainder == dividend holds exactly in 2*WIDTH bits.
  - The remainder output is the low WIDTH bits of the partial remainder; the MSB is always 0 at completion.
- Boundaries:
  - dividend < divisor gives quotient=0, remainder=dividend.
  - dividend==0 gives quotient=0, remainder=0.
  - divisor==1 gives quotient=dividend, remainder=0.
  - Maximum operands need no overflow handling, because the partial remainder is WIDTH+1 bits.
  - The counter is sized ceil(log2(WIDTH+1)) bits and never wraps within an operation.
- Throughput: one operation per WIDTH+2 cycles minimum (accept, WIDTH steps, drain).

Test Plan:
- WIDTH=32, dividend=100, divisor=7, out_ready=1 -> out_valid exactly 32 cycles after accept edge; quotient=14, remainder=2, div_by_zero=0; in_ready back high 1 cycle after drain.
- dividend=0xDEADBEEF, divisor=0 -> out_valid in the cycle after accept; quotient=0xFFFFFFFF, remainder=0xDEADBEEF, div_by_zero=1.
- dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0. Then dividend=5, divisor=9 -> quotient=0, remainder=5.
- Backpressure:
  - hold out_ready=0 for 10 cycles after out_valid -> outputs unchanged and in_ready=0 throughout;
  - a new in_valid pulse during CALC/DONE is not accepted;
  - releasing out_ready drains exactly one result.
- Reset mid-op: assert rst_n=0 at step 16 of 1000/3 -> all outputs 0 and in_ready=1 immediately (asynchronous). A subsequent 81/9 returns quotient=9, remainder=0 after 32 cycles.
- Random: 10k random operand pairs with random out_ready stalls, WIDTH=4 and 32 -> every result satisfies quotient*divisor+remainder==dividend (product from the Vedic multiplier) and remainder<divisor; latency always WIDTH.
